// File: rtl/stack_alu_pkg.sv
// Shared constants and types for the stack ALU: opcodes, FSM states,
// flag bit positions and the iterative-unit operation selector.
package stack_alu_pkg;

    // Binary opcodes (arg_cnt = 1)
    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_AND = 4'd2;
    localparam logic [3:0] FN_OR  = 4'd3;
    localparam logic [3:0] FN_XOR = 4'd4;
    localparam logic [3:0] FN_SRA = 4'd5;
    localparam logic [3:0] FN_SRL = 4'd6;
    localparam logic [3:0] FN_SLL = 4'd7;
    localparam logic [3:0] FN_MUL = 4'd8;

    // Unary opcodes (arg_cnt = 0)
    localparam logic [3:0] UFN_PASS = 4'd0;
    localparam logic [3:0] UFN_NOT  = 4'd1;
    localparam logic [3:0] UFN_NEG  = 4'd2;

    // Bit positions inside the {Z,N,C,V} flag vector
    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        IT_SRA = 2'd0,
        IT_SRL = 2'd1,
        IT_SLL = 2'd2,
        IT_MUL = 2'd3
    } iter_op_t;

endpackage

// File: rtl/stack_alu_iter_unit.sv
// Iterative datapath for shifts and multiply. The start cycle loads the
// operands and already performs the first step, so an n-step operation
// leaves o_busy high for n-1 cycles after the start edge.
module alu_iter_unit
    import stack_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  iter_op_t           i_op,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_busy,
    output logic [2*WIDTH-1:0] o_acc,
    output logic               o_carry
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [CW-1:0]      r_cnt;
    iter_op_t           r_op;
    logic               r_carry;

    logic [CW-1:0]      w_n;
    iter_op_t           w_src_op;
    logic [2*WIDTH-1:0] w_src_acc;
    logic [WIDTH-1:0]   w_src_mcand;
    logic [CW-1:0]      w_src_cnt;
    logic [WIDTH-1:0]   w_lo;
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_nxt_acc;
    logic               w_nxt_carry;

    // Step count: mul always takes WIDTH steps, shifts saturate at WIDTH
    assign w_n = (i_op == IT_MUL || i_b >= WIDTH'(WIDTH)) ? CW'(WIDTH) : i_b[CW-1:0];

    // Select step source: fresh operands on start, otherwise the running state
    always_comb begin
        w_src_op    = r_op;
        w_src_acc   = r_acc;
        w_src_mcand = r_mcand;
        w_src_cnt   = r_cnt;
        if (i_start) begin
            w_src_op    = i_op;
            w_src_mcand = i_a;
            w_src_cnt   = w_n;
            w_src_acc   = (i_op == IT_MUL) ? {{WIDTH{1'b0}}, i_b} : {{WIDTH{1'b0}}, i_a};
        end
    end

    assign w_lo  = w_src_acc[WIDTH-1:0];
    assign w_hi  = w_src_acc[2*WIDTH-1:WIDTH];
    assign w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_src_mcand} : {(WIDTH+1){1'b0}});

    // One shift or shift-add step; shifts keep their value in the low half
    always_comb begin
        w_nxt_acc   = w_src_acc;
        w_nxt_carry = r_carry;
        case (w_src_op)
            IT_SRA: begin
                w_nxt_acc   = {{WIDTH{1'b0}}, w_lo[WIDTH-1], w_lo[WIDTH-1:1]};
                w_nxt_carry = w_lo[0];
            end
            IT_SRL: begin
                w_nxt_acc   = {{WIDTH{1'b0}}, 1'b0, w_lo[WIDTH-1:1]};
                w_nxt_carry = w_lo[0];
            end
            IT_SLL: begin
                w_nxt_acc   = {{WIDTH{1'b0}}, w_lo[WIDTH-2:0], 1'b0};
                w_nxt_carry = w_lo[WIDTH-1];
            end
            default: begin
                w_nxt_acc   = {w_sum, w_lo[WIDTH-1:1]};
                w_nxt_carry = 1'b0;
            end
        endcase
    end

    // Advance one step per cycle while work remains
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
            r_op    <= IT_SRA;
            r_carry <= 1'b0;
        end else if (i_start || r_cnt != '0) begin
            r_acc   <= w_nxt_acc;
            r_mcand <= w_src_mcand;
            r_cnt   <= w_src_cnt - CW'(1);
            r_op    <= w_src_op;
            r_carry <= w_nxt_carry;
        end
    end

    assign o_busy  = (r_cnt != '0);
    assign o_acc   = r_acc;
    assign o_carry = r_carry;

endmodule

// File: rtl/stack_alu.sv
// Handshaked stack ALU. Single-cycle ops are resolved at accept; shifts
// with a non-zero amount and multiply are handed to alu_iter_unit.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | in_ready high, waiting for an operation
// ITER    | iterative unit running a shift or multiply
// DONE    | result held on q/flags/err until out_ready
module stack_alu
    import stack_alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       fn_sel,
    input  logic             arg_cnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [3:0]       flags,
    output logic             err
);

    localparam int MSB = WIDTH - 1;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_q;
    logic [3:0]       r_flags;
    logic             r_err;
    logic             r_is_mul;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic               w_err;
    logic               w_iter;
    iter_op_t           w_it_op;
    logic [3:0]         w_flags;
    logic               w_start;
    logic               w_it_busy;
    logic [2*WIDTH-1:0] w_it_acc;
    logic               w_it_carry;
    logic [WIDTH-1:0]   w_it_q;
    logic [3:0]         w_it_flags;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = a - b;

    // Decode the presented operation into a one-cycle result or an iterative start
    always_comb begin
        w_res   = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        w_err   = 1'b0;
        w_iter  = 1'b0;
        w_it_op = IT_SRA;
        if (arg_cnt) begin
            case (fn_sel)
                FN_ADD: begin
                    w_res = w_sum[WIDTH-1:0];
                    w_c   = w_sum[WIDTH];
                    w_v   = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
                end
                FN_SUB: begin
                    w_res = w_diff;
                    w_c   = (a >= b);
                    w_v   = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
                end
                FN_AND: w_res = a & b;
                FN_OR:  w_res = a | b;
                FN_XOR: w_res = a ^ b;
                FN_SRA, FN_SRL, FN_SLL: begin
                    // A zero shift amount passes a through without entering ITER
                    if (b == '0) begin
                        w_res = a;
                    end else begin
                        w_iter  = 1'b1;
                        w_it_op = (fn_sel == FN_SRA) ? IT_SRA :
                                  (fn_sel == FN_SRL) ? IT_SRL : IT_SLL;
                    end
                end
                FN_MUL: begin
                    if (MUL_EN != 0) begin
                        w_iter  = 1'b1;
                        w_it_op = IT_MUL;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                default: w_err = 1'b1;
            endcase
        end else begin
            case (fn_sel)
                UFN_PASS: w_res = a;
                UFN_NOT:  w_res = ~a;
                UFN_NEG: begin
                    w_res = '0 - a;
                    w_v   = (a == {1'b1, {(WIDTH-1){1'b0}}});
                end
                default: w_err = 1'b1;
            endcase
        end
    end

    assign w_flags = w_err ? 4'b0000 : {(w_res == '0), w_res[MSB], w_c, w_v};

    assign w_start = (r_state == ST_IDLE) && in_valid && w_iter;

    alu_iter_unit #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_op    (w_it_op),
        .i_a     (a),
        .i_b     (b),
        .o_busy  (w_it_busy),
        .o_acc   (w_it_acc),
        .o_carry (w_it_carry)
    );

    assign w_it_q     = w_it_acc[WIDTH-1:0];
    assign w_it_flags = {(w_it_q == '0), w_it_q[MSB],
                         r_is_mul ? (w_it_acc[2*WIDTH-1:WIDTH] != '0) : w_it_carry,
                         1'b0};

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_q         <= '0;
            r_flags     <= '0;
            r_err       <= 1'b0;
            r_is_mul    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        if (w_iter) begin
                            r_state  <= ST_ITER;
                            r_is_mul <= (w_it_op == IT_MUL);
                        end else begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_q         <= w_res;
                            r_flags     <= w_flags;
                            r_err       <= w_err;
                        end
                    end
                end
                ST_ITER: begin
                    if (!w_it_busy) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_q         <= w_it_q;
                        r_flags     <= w_it_flags;
                        r_err       <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign q         = r_q;
    assign flags     = r_flags;
    assign err       = r_err;

endmodule

// File: tb/tb_stack_alu.sv
// Directed bench for stack_alu at WIDTH=8, plus a MUL_EN=0 instance for
// the disabled-multiply case.
module tb_stack_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, out_ready, arg_cnt;
    logic [7:0] a, b;
    logic [3:0] fn_sel;
    logic       in_ready, out_valid, err;
    logic [7:0] q;
    logic [3:0] flags;

    logic       in_valid0, out_ready0, arg_cnt0;
    logic [7:0] a0, b0;
    logic [3:0] fn_sel0;
    logic       in_ready0, out_valid0, err0;
    logic [7:0] q0;
    logic [3:0] flags0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stack_alu #(.WIDTH(8), .MUL_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .fn_sel(fn_sel), .arg_cnt(arg_cnt),
        .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .flags(flags), .err(err)
    );

    stack_alu #(.WIDTH(8), .MUL_EN(0)) dut_nomul (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a0), .b(b0), .fn_sel(fn_sel0), .arg_cnt(arg_cnt0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .q(q0), .flags(flags0), .err(err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op (out_ready held high), measure latency, check result, complete handshake
    task automatic do_op(input string tag, input logic ac, input logic [3:0] fn,
                         input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] exp_q, input logic [3:0] exp_f,
                         input logic exp_e, input int exp_lat);
        int lat;
        arg_cnt  = ac;
        fn_sel   = fn;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_lat"},   lat,       exp_lat);
        check({tag, "_vld"},   out_valid, 1);
        check({tag, "_q"},     q,         exp_q);
        check({tag, "_flags"}, flags,     exp_f);
        check({tag, "_err"},   err,       exp_e);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; arg_cnt = 1'b0;
        a = '0; b = '0; fn_sel = '0;
        in_valid0 = 1'b0; out_ready0 = 1'b1; arg_cnt0 = 1'b0;
        a0 = '0; b0 = '0; fn_sel0 = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_q",         q,         0);
        check("rst_flags",     flags,     0);
        check("rst_err",       err,       0);

        //     tag         ac    fn     a      b      q      ZNCV     err lat
        do_op("add_ovf",  1'b1, 4'd0, 8'h7F, 8'h01, 8'h80, 4'b0101, 0, 1);
        do_op("add_wrap", 1'b1, 4'd0, 8'hFF, 8'h01, 8'h00, 4'b1010, 0, 1);
        do_op("sub_brw",  1'b1, 4'd1, 8'h00, 8'h01, 8'hFF, 4'b0100, 0, 1);
        do_op("sub_nb",   1'b1, 4'd1, 8'h05, 8'h03, 8'h02, 4'b0010, 0, 1);
        do_op("and",      1'b1, 4'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000, 0, 1);
        do_op("or",       1'b1, 4'd3, 8'h50, 8'h0A, 8'h5A, 4'b0000, 0, 1);
        do_op("sra3",     1'b1, 4'd5, 8'h80, 8'h03, 8'hF0, 4'b0100, 0, 4);
        do_op("sra9",     1'b1, 4'd5, 8'h80, 8'h09, 8'hFF, 4'b0110, 0, 9);
        do_op("sll1",     1'b1, 4'd7, 8'h81, 8'h01, 8'h02, 4'b0010, 0, 2);
        do_op("srl0",     1'b1, 4'd6, 8'h55, 8'h00, 8'h55, 4'b0000, 0, 1);
        do_op("srl8",     1'b1, 4'd6, 8'h80, 8'h08, 8'h00, 4'b1010, 0, 9);
        do_op("sll200",   1'b1, 4'd7, 8'h01, 8'hC8, 8'h00, 4'b1010, 0, 9);
        do_op("mul_hi",   1'b1, 4'd8, 8'h10, 8'h11, 8'h10, 4'b0010, 0, 9);
        do_op("mul_lo",   1'b1, 4'd8, 8'h07, 8'h06, 8'h2A, 4'b0000, 0, 9);
        do_op("bin_ill",  1'b1, 4'd9, 8'h12, 8'h34, 8'h00, 4'b0000, 1, 1);
        do_op("neg_min",  1'b0, 4'd2, 8'h80, 8'h00, 8'h80, 4'b0101, 0, 1);
        do_op("not_ff",   1'b0, 4'd1, 8'hFF, 8'h00, 8'h00, 4'b1000, 0, 1);
        do_op("un_ill",   1'b0, 4'd5, 8'h12, 8'h00, 8'h00, 4'b0000, 1, 1);

        // Multiply with MUL_EN=0 is illegal with one-cycle latency
        arg_cnt0 = 1'b1; fn_sel0 = 4'd8; a0 = 8'h10; b0 = 8'h11; in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        check("nomul_vld", out_valid0, 1);
        check("nomul_q",   q0,         0);
        check("nomul_err", err0,       1);
        check("nomul_flg", flags0,     0);
        tick();

        // Backpressure: result must hold while a new request waits
        out_ready = 1'b0;
        arg_cnt = 1'b1; fn_sel = 4'd0; a = 8'h02; b = 8'h03; in_valid = 1'b1;
        tick();
        fn_sel = 4'd4; a = 8'hF0; b = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            check("bp_vld",   out_valid, 1);
            check("bp_q",     q,         8'h05);
            check("bp_flags", flags,     4'b0000);
            check("bp_rdy",   in_ready,  0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_hs_vld", out_valid, 0);
        check("bp_hs_rdy", in_ready,  1);
        tick();
        in_valid = 1'b0;
        check("bp_next_vld", out_valid, 1);
        check("bp_next_q",   q,         8'h0F);
        check("bp_next_flg", flags,     4'b0000);
        tick();

        // Reset during the fourth multiply iteration drops the operation
        arg_cnt = 1'b1; fn_sel = 4'd8; a = 8'h10; b = 8'h11; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstm_vld", out_valid, 0);
        check("rstm_rdy", in_ready,  1);
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                if (out_valid) seen++;
                tick();
            end
            check("rstm_no_out", seen, 0);
        end
        do_op("post_add", 1'b1, 4'd0, 8'h02, 8'h03, 8'h05, 4'b0000, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/stack_alu.md
# stack_alu

Parametrised, handshaked ALU for the stack datapath, replacing the combinational 8-bit ALU. The stack controller pops operands into it over a valid/ready input and pushes results back over a valid/ready output. Simple ops finish in one cycle; shifts and multiply run iteratively. Every result carries a ZNCV flag set, and illegal opcodes are reported instead of producing X.

## Interface
Parameters:
- `WIDTH`, default 8: data width. Legal values are 2 or more.
- `MUL_EN`, default 1: enables the iterative multiply. When 0, the multiply opcode is illegal.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `in_valid` in 1: operands and opcode are valid.
- `in_ready` out 1: block can accept an operation.
- `a` in `WIDTH`: top of stack (first operand).
- `b` in `WIDTH`: second operand. Ignored for unary ops.
- `fn_sel` in 4: operation code.
- `arg_cnt` in 1: 1 selects a binary op, 0 selects a unary op.
- `out_valid` out 1: result is valid.
- `out_ready` in 1: consumer takes the result.
- `q` out `WIDTH`: result.
- `flags` out 4: {Z,N,C,V}.
- `err` out 1: the opcode was illegal.

## Operation
- States: `IDLE`, `ITER`, `DONE`.
- `in_ready` = (state == `IDLE`).
- Accept happens on a clock edge with `in_valid && in_ready`. At accept, `a`, `b`, `fn_sel` and `arg_cnt` are registered.
- Binary ops (`arg_cnt`=1):
  - 0 add; 1 sub; 2 and; 3 or; 4 xor.
  - 5 sra; 6 srl; 7 sll.
  - 8 mul, keeping the low `WIDTH` bits.
  - 9–15 illegal.
- Unary ops (`arg_cnt`=0): 0 pass `a`; 1 `~a`; 2 two's-complement negate. 3–15 illegal.
- Shifts iterate one bit per cycle, n = min(`b`, `WIDTH`) iterations. `b` is unsigned and its full width is used.
  - If `b` ≥ `WIDTH`: srl/sll give 0; sra gives all copies of the sign bit.
  - If `b` = 0: `a` passes through unchanged, with no `ITER` cycles.
- Mul is shift-add over exactly `WIDTH` iterations on a 2×`WIDTH` accumulator.
- Flags:
  - Z = (`q` == 0). N = `q[WIDTH-1]`.
  - C for add: carry out.
  - C for sub: no-borrow (1 iff `a` ≥ `b` unsigned).
  - C for shifts: the last bit shifted out (0 if n = 0).
  - C for mul: 1 iff the high half is non-zero.
  - C for all other ops: 0.
  - V for add/sub: signed overflow. V for neg: 1 iff `a` is the most negative value. V for all other ops: 0.
- Illegal opcode: `q`=0, `flags`=0, `err`=1. It completes with 1-cycle latency, so there is no hang.
- Transitions:
  - `IDLE`→`DONE` on accept of a 1-cycle op.
  - `IDLE`→`ITER` on accept of a shift with n>0, or of a mul.
  - `ITER`→`DONE` when the iteration count hits zero.
  - `DONE`→`IDLE` on `out_ready`.
- `out_valid` = (state == `DONE`). `q`, `flags` and `err` are registered and stable while `out_valid && !out_ready`.

## Timing
- Latency is counted from the accept edge to the first cycle `out_valid` is high:
  - Logic, add/sub, unary, illegal: 1.
  - Shifts: 1+n.
  - Mul: 1+`WIDTH`.
- No accept in the same cycle as an output handshake. The next accept is possible one cycle after the output handshake, since `in_ready` rises in `IDLE`.
- Reset values: state `IDLE`, `out_valid`=0, `in_ready`=1 from the first cycle after reset, `q`=0, `flags`=0, `err`=0.
- `rst` during `ITER` or `DONE` drops the operation. `out_valid` is 0 on the next cycle and no result is ever emitted.
- `in_valid` while busy is ignored. The stack controller holds its request until `in_ready`.
- Width rules: all arithmetic is modulo 2^`WIDTH`. Shift amount compare uses the full `b`. The internal counter is $clog2(`WIDTH`+1) bits.

## Structure
- Package `stack_alu_pkg` holds:
  - the opcode constants (`FN_ADD`…`FN_MUL`, `UFN_PASS`/`UFN_NOT`/`UFN_NEG`);
  - the state enum;
  - the flag bit indices `FLG_Z`/`FLG_N`/`FLG_C`/`FLG_V`.
- Sub-module `alu_iter_unit` holds the shift/mul datapath, counter and accumulator. It has a start/done interface and is instantiated once.
- The top level holds the FSM, the single-cycle ops, flag generation and the output registers.

## Test plan
All scenarios use `WIDTH`=8.
- Add 0x7F+0x01 → `q`=0x80, Z0 N1 C0 V1, `out_valid` 1 cycle after accept. Sub 0x00−0x01 → 0xFF, C0 N1.
- Shifts:
  - sra 0x80 by 3 → 0xF0, C0, latency 4.
  - sra 0x80 by 9 → 0xFF, latency 9.
  - sll 0x81 by 1 → 0x02, C1, latency 2.
  - srl 0x55 by 0 → 0x55, latency 1.
- Mul 0x10×0x11 → `q`=0x10, C1, latency 9. With `MUL_EN`=0 the same op → `q`=0, `err`=1, latency 1.
- Unary: neg 0x80 → 0x80, V1. Not 0xFF → 0x00, Z1. `arg_cnt`=0 with `fn_sel`=5 → `err`=1, `q`=0.
- Backpressure: hold `out_ready`=0 for 3 cycles. `q`, `flags` and `out_valid` stay stable, `in_ready` stays 0, and a pending `in_valid` is not accepted until the cycle after the output handshake.
- Assert `rst` mid-mul (iteration 4). `out_valid` stays 0 and `in_ready`=1 on the next cycle. A following add 2+3 returns 0x05 with correct flags.
